bus_matrix_axi_splitter: RTL and testbench

Single-master to M-slave AXI4-Lite splitter with pipelined outstanding transactions. Each of the read and write directions accepts up to MAX_OUTSTANDING address beats before the first response returns. It sits downstream of a matrix master port or a CPU port where one-at-a-time locking costs too much throughput. Unmapped addresses are terminated by an internal DECERR responder.

---
 rtl/bus_matrix_axi_splitter.sv | 240 ++++++++++++++++++++++++
 tb/tb_bus_matrix_axi_splitter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_matrix_axi_splitter.sv
// AXI4-Lite 1-to-M splitter with pipelined outstanding transactions per direction.
// Unmapped addresses go to an internal DECERR responder (target index M_SLAVES).
module bus_matrix_axi_splitter #(
    parameter int M_SLAVES        = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [M_SLAVES*ADDR_WIDTH-1:0] SLV_BASE_FLAT = '0,
    parameter logic [M_SLAVES*ADDR_WIDTH-1:0] SLV_MASK_FLAT = '0
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [ADDR_WIDTH-1:0]            awaddr_i,
    input  logic [2:0]                       awprot_i,
    input  logic                             awvalid_i,
    output logic                             awready_o,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
    input  logic                             wvalid_i,
    output logic                             wready_o,
    output logic [1:0]                       bresp_o,
    output logic                             bvalid_o,
    input  logic                             bready_i,
    input  logic [ADDR_WIDTH-1:0]            araddr_i,
    input  logic [2:0]                       arprot_i,
    input  logic                             arvalid_i,
    output logic                             arready_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [1:0]                       rresp_o,
    output logic                             rvalid_o,
    input  logic                             rready_i,
    output logic [M_SLAVES*ADDR_WIDTH-1:0]   s_awaddr_o,
    output logic [M_SLAVES*3-1:0]            s_awprot_o,
    output logic [M_SLAVES-1:0]              s_awvalid_o,
    input  logic [M_SLAVES-1:0]              s_awready_i,
    output logic [M_SLAVES*DATA_WIDTH-1:0]   s_wdata_o,
    output logic [M_SLAVES*DATA_WIDTH/8-1:0] s_wstrb_o,
    output logic [M_SLAVES-1:0]              s_wvalid_o,
    input  logic [M_SLAVES-1:0]              s_wready_i,
    input  logic [M_SLAVES*2-1:0]            s_bresp_i,
    input  logic [M_SLAVES-1:0]              s_bvalid_i,
    output logic [M_SLAVES-1:0]              s_bready_o,
    output logic [M_SLAVES*ADDR_WIDTH-1:0]   s_araddr_o,
    output logic [M_SLAVES*3-1:0]            s_arprot_o,
    output logic [M_SLAVES-1:0]              s_arvalid_o,
    input  logic [M_SLAVES-1:0]              s_arready_i,
    input  logic [M_SLAVES*DATA_WIDTH-1:0]   s_rdata_i,
    input  logic [M_SLAVES*2-1:0]            s_rresp_i,
    input  logic [M_SLAVES-1:0]              s_rvalid_i,
    output logic [M_SLAVES-1:0]              s_rready_o
);

    localparam int TW = $clog2(M_SLAVES + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [TW-1:0] ERR  = TW'(M_SLAVES);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

    // Lowest-index hit wins because the loop walks down and overwrites.
    function automatic logic [TW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [TW-1:0] t;
        t = ERR;
        for (int i = M_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK_FLAT[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLV_BASE_FLAT[i*ADDR_WIDTH +: ADDR_WIDTH])
                t = TW'(i);
        end
        return t;
    endfunction

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [CW-1:0] r_wCnt, r_wErr, r_fCnt, r_rCnt, r_rErr;
    logic [TW-1:0] r_wTgt, r_rTgt;
    logic [PW-1:0] r_fRd, r_fWr;
    logic [TW-1:0] r_fifo [MAX_OUTSTANDING];

    logic [TW-1:0] w_awTgt, w_wHead, w_arTgt;
    logic w_awAllow, w_awSlvReady, w_awHs;
    logic w_fEmpty, w_wHeadVld, w_wSlvReady, w_wHs, w_push, w_pop;
    logic w_bSlvValid, w_bHs, w_wErrInc, w_bErrDec;
    logic [1:0] w_bSlvResp;
    logic w_arAllow, w_arSlvReady, w_arHs;
    logic w_rSlvValid, w_rHs, w_rErrInc, w_rErrDec;
    logic [1:0] w_rSlvResp;
    logic [DATA_WIDTH-1:0] w_rSlvData;

    // Write address, W routing and B return path.
    always_comb begin
        w_awTgt      = decode(awaddr_i);
        w_awAllow    = !areset && (r_wCnt < MAXC) && (r_wCnt == '0 || w_awTgt == r_wTgt);
        w_awSlvReady = 1'b1;
        s_awvalid_o  = '0;
        s_awaddr_o   = '0;
        s_awprot_o   = '0;
        for (int i = 0; i < M_SLAVES; i++) begin
            if (w_awTgt == TW'(i)) begin
                w_awSlvReady = s_awready_i[i];
                if (w_awAllow) begin
                    s_awvalid_o[i]                       = awvalid_i;
                    s_awaddr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = awaddr_i;
                    s_awprot_o[i*3 +: 3]                 = awprot_i;
                end
            end
        end
        awready_o = w_awAllow && w_awSlvReady;
        w_awHs    = awvalid_i && awready_o;

        w_fEmpty    = (r_fCnt == '0);
        w_wHead     = w_fEmpty ? w_awTgt : r_fifo[r_fRd];
        w_wHeadVld  = !areset && (!w_fEmpty || w_awHs);
        w_wSlvReady = 1'b1;
        s_wvalid_o  = '0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        for (int i = 0; i < M_SLAVES; i++) begin
            if (w_wHead == TW'(i)) begin
                w_wSlvReady = s_wready_i[i];
                if (w_wHeadVld) begin
                    s_wvalid_o[i]                          = wvalid_i;
                    s_wdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = wdata_i;
                    s_wstrb_o[i*SW +: SW]                  = wstrb_i;
                end
            end
        end
        wready_o  = w_wHeadVld && w_wSlvReady;
        w_wHs     = wvalid_i && wready_o;
        w_push    = w_awHs && !(w_fEmpty && w_wHs);
        w_pop     = w_wHs && !w_fEmpty;
        w_wErrInc = w_wHs && (w_wHead == ERR);

        w_bSlvValid = 1'b0;
        w_bSlvResp  = 2'b00;
        s_bready_o  = '0;
        for (int i = 0; i < M_SLAVES; i++) begin
            if (r_wTgt == TW'(i)) begin
                w_bSlvValid = s_bvalid_i[i];
                w_bSlvResp  = s_bresp_i[i*2 +: 2];
                s_bready_o[i] = bready_i && (r_wCnt != '0);
            end
        end
        if (r_wTgt == ERR) begin
            bvalid_o = (r_wCnt != '0) && (r_wErr != '0);
            bresp_o  = 2'b11;
        end else begin
            bvalid_o = (r_wCnt != '0) && w_bSlvValid;
            bresp_o  = w_bSlvResp;
        end
        w_bHs     = bvalid_o && bready_i;
        w_bErrDec = w_bHs && (r_wTgt == ERR);
    end

    always_comb begin
        w_arTgt      = decode(araddr_i);
        w_arAllow    = !areset && (r_rCnt < MAXC) && (r_rCnt == '0 || w_arTgt == r_rTgt);
        w_arSlvReady = 1'b1;
        s_arvalid_o  = '0;
        s_araddr_o   = '0;
        s_arprot_o   = '0;
        for (int i = 0; i < M_SLAVES; i++) begin
            if (w_arTgt == TW'(i)) begin
                w_arSlvReady = s_arready_i[i];
                if (w_arAllow) begin
                    s_arvalid_o[i]                         = arvalid_i;
                    s_araddr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = araddr_i;
                    s_arprot_o[i*3 +: 3]                   = arprot_i;
                end
            end
        end
        arready_o = w_arAllow && w_arSlvReady;
        w_arHs    = arvalid_i && arready_o;
        w_rErrInc = w_arHs && (w_arTgt == ERR);

        w_rSlvValid = 1'b0;
        w_rSlvResp  = 2'b00;
        w_rSlvData  = '0;
        s_rready_o  = '0;
        for (int i = 0; i < M_SLAVES; i++) begin
            if (r_rTgt == TW'(i)) begin
                w_rSlvValid = s_rvalid_i[i];
                w_rSlvResp  = s_rresp_i[i*2 +: 2];
                w_rSlvData  = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_rready_o[i] = rready_i && (r_rCnt != '0);
            end
        end
        if (r_rTgt == ERR) begin
            rvalid_o = (r_rCnt != '0) && (r_rErr != '0);
            rresp_o  = 2'b11;
            rdata_o  = '0;
        end else begin
            rvalid_o = (r_rCnt != '0) && w_rSlvValid;
            rresp_o  = w_rSlvResp;
            rdata_o  = w_rSlvData;
        end
        w_rHs     = rvalid_o && rready_i;
        w_rErrDec = w_rHs && (r_rTgt == ERR);
    end

    // Outstanding counters, targets, DECERR credit counters and the W-route FIFO.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wCnt <= '0;
            r_wErr <= '0;
            r_wTgt <= '0;
            r_rCnt <= '0;
            r_rErr <= '0;
            r_rTgt <= '0;
            r_fCnt <= '0;
            r_fRd  <= '0;
            r_fWr  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
        end else begin
            if (w_awHs && !w_bHs)      r_wCnt <= r_wCnt + CW'(1);
            else if (!w_awHs && w_bHs) r_wCnt <= r_wCnt - CW'(1);
            if (w_awHs) r_wTgt <= w_awTgt;

            if (w_wErrInc && !w_bErrDec)      r_wErr <= r_wErr + CW'(1);
            else if (!w_wErrInc && w_bErrDec) r_wErr <= r_wErr - CW'(1);

            if (w_push) begin
                r_fifo[r_fWr] <= w_awTgt;
                r_fWr         <= nextPtr(r_fWr);
            end
            if (w_pop) r_fRd <= nextPtr(r_fRd);
            if (w_push && !w_pop)      r_fCnt <= r_fCnt + CW'(1);
            else if (!w_push && w_pop) r_fCnt <= r_fCnt - CW'(1);

            if (w_arHs && !w_rHs)      r_rCnt <= r_rCnt + CW'(1);
            else if (!w_arHs && w_rHs) r_rCnt <= r_rCnt - CW'(1);
            if (w_arHs) r_rTgt <= w_arTgt;

            if (w_rErrInc && !w_rErrDec)      r_rErr <= r_rErr + CW'(1);
            else if (!w_rErrInc && w_rErrDec) r_rErr <= r_rErr - CW'(1);
        end
    end

endmodule

// File: tb/tb_bus_matrix_axi_splitter.sv
// Scoreboard bench for bus_matrix_axi_splitter: 4 slaves at 0x1-0x4 top nibble,
// everything else (including 0x0 and 0xF) unmapped.
module tb_bus_matrix_axi_splitter;

    localparam int M  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            aclk = 1'b0;
    logic            areset;
    logic [AW-1:0]   awaddr_i, araddr_i;
    logic [2:0]      awprot_i, arprot_i;
    logic            awvalid_i, awready_o, wvalid_i, wready_o;
    logic [DW-1:0]   wdata_i, rdata_o;
    logic [DW/8-1:0] wstrb_i;
    logic [1:0]      bresp_o, rresp_o;
    logic            bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
    logic [M*AW-1:0] s_awaddr_o, s_araddr_o;
    logic [M*3-1:0]  s_awprot_o, s_arprot_o;
    logic [M-1:0]    s_awvalid_o, s_awready_i, s_wvalid_o, s_wready_i;
    logic [M*DW-1:0] s_wdata_o, s_rdata_i;
    logic [M*DW/8-1:0] s_wstrb_o;
    logic [M*2-1:0]  s_bresp_i, s_rresp_i;
    logic [M-1:0]    s_bvalid_i, s_bready_o, s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o;

    bus_matrix_axi_splitter #(
        .M_SLAVES(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(4),
        .SLV_BASE_FLAT({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .SLV_MASK_FLAT({4{32'hF000_0000}})
    ) dut (
        .aclk(aclk), .areset(areset),
        .awaddr_i(awaddr_i), .awprot_i(awprot_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .araddr_i(araddr_i), .arprot_i(arprot_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .s_awaddr_o(s_awaddr_o), .s_awprot_o(s_awprot_o), .s_awvalid_o(s_awvalid_o),
        .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wvalid_o(s_wvalid_o),
        .s_wready_i(s_wready_i),
        .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
        .s_araddr_o(s_araddr_o), .s_arprot_o(s_arprot_o), .s_arvalid_o(s_arvalid_o),
        .s_arready_i(s_arready_i),
        .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rvalid_i(s_rvalid_i),
        .s_rready_o(s_rready_o)
    );

    always #5 aclk = ~aclk;

    int checkCount = 0;
    int failCount  = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic awv, input logic [AW-1:0] addr,
                                 input logic wv, input logic [DW-1:0] data);
        awvalid_i = awv;
        awaddr_i  = addr;
        awprot_i  = 3'b010;
        wvalid_i  = wv;
        wdata_i   = data;
        wstrb_i   = 4'hF;
    endtask

    task automatic nextCycle();
        @(posedge aclk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every B/R handshake, sampled mid-cycle.
    always @(negedge aclk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (!areset && bvalid_o && bready_i) begin
            if (bq.size() == 0) checkOutput("b_extra", 128'(bq.size()), 128'd1);
            else begin
                eb = bq.pop_front();
                checkOutput("b_resp", 128'(bresp_o), 128'(eb));
            end
        end
        if (!areset && rvalid_o && rready_i) begin
            if (rq.size() == 0) checkOutput("r_extra", 128'(rq.size()), 128'd1);
            else begin
                er = rq.pop_front();
                checkOutput("r_beat", 128'({rresp_o, rdata_o}), 128'(er));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Slave-side constants: each slave returns a distinct response/data.
        s_awready_i = 4'hF;
        s_wready_i  = 4'hF;
        s_arready_i = 4'hF;
        s_bresp_i   = {2'b11, 2'b00, 2'b10, 2'b01};
        s_rresp_i   = {2'b00, 2'b10, 2'b01, 2'b00};
        s_rdata_i   = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        s_bvalid_i  = 4'hF;
        s_rvalid_i  = 4'hF;
        areset      = 1'b1;
        applyStimulus(1'b1, 32'h1000_0000, 1'b1, 32'h1);
        arvalid_i = 1'b1; araddr_i = 32'h1000_0000; arprot_i = 3'b000;
        bready_i  = 1'b1; rready_i = 1'b1;
        repeat (2) @(posedge aclk);
        #2;
        checkOutput("rst_valids", 128'({awready_o, wready_o, s_awvalid_o, s_wvalid_o, arready_o,
                    s_arvalid_o, bvalid_o, rvalid_o, s_bready_o, s_rready_o}), 128'd0);
        checkOutput("rst_awready", 128'(awready_o), 128'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        arvalid_i = 1'b0; bready_i = 1'b0; rready_i = 1'b0;
        s_bvalid_i = 4'h0; s_rvalid_i = 4'h0;
        areset = 1'b0;
        nextCycle();

        // Outstanding limit with slave 1 holding B low.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h2000_0100 + 32'(k * 4), 1'b1, 32'hA0 + 32'(k));
            #1;
            checkOutput("t1_awready", 128'(awready_o), 128'd1);
            checkOutput("t1_sawvalid", 128'(s_awvalid_o), 128'b0010);
            bq.push_back(2'b10);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h2000_0110, 1'b1, 32'hA4);
        #1;
        checkOutput("t1_awfull", 128'(awready_o), 128'd0);
        checkOutput("t1_wstall", 128'(wready_o), 128'd0);
        nextCycle();
        s_bvalid_i = 4'b0010; bready_i = 1'b1;
        #1;
        checkOutput("t1_bvalid", 128'(bvalid_o), 128'd1);
        checkOutput("t1_aw_still", 128'(awready_o), 128'd0);
        nextCycle();
        s_bvalid_i = 4'b0000;
        #1;
        checkOutput("t1_aw5", 128'(awready_o), 128'd1);
        checkOutput("t1_w5", 128'(wready_o), 128'd1);
        bq.push_back(2'b10);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        s_bvalid_i = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("t1_drain", 128'(bvalid_o), 128'd1);
            nextCycle();
        end
        #1;
        checkOutput("t1_bdone", 128'({bvalid_o, s_bready_o}), 128'd0);
        s_bvalid_i = 4'b0000;
        nextCycle();

        // A different target stalls until the earlier write's B completes.
        applyStimulus(1'b1, 32'h1000_0000, 1'b1, 32'hB0);
        #1;
        checkOutput("t2_aw0", 128'(awready_o), 128'd1);
        bq.push_back(2'b01);
        nextCycle();
        applyStimulus(1'b1, 32'h3000_0000, 1'b1, 32'hB2);
        #1;
        checkOutput("t2_stall", 128'(awready_o), 128'd0);
        checkOutput("t2_noslv", 128'(s_awvalid_o), 128'd0);
        nextCycle();
        s_bvalid_i = 4'b0001;
        #1;
        checkOutput("t2_stall_b", 128'(awready_o), 128'd0);
        nextCycle();
        s_bvalid_i = 4'b0000;
        #1;
        checkOutput("t2_sawvalid", 128'(s_awvalid_o), 128'b0100);
        checkOutput("t2_sawaddr", 128'(s_awaddr_o), 128'h3000_0000 << 64);
        checkOutput("t2_sawprot", 128'(s_awprot_o), 128'b010 << 6);
        checkOutput("t2_swvalid", 128'(s_wvalid_o), 128'b0100);
        checkOutput("t2_swdata", 128'(s_wdata_o), 128'hB2 << 64);
        bq.push_back(2'b00);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        s_bvalid_i = 4'b0100;
        #1;
        checkOutput("t2_bvalid", 128'(bvalid_o), 128'd1);
        nextCycle();
        s_bvalid_i = 4'b0000;

        // Unmapped write terminates internally with DECERR.
        applyStimulus(1'b1, 32'hF000_0000, 1'b1, 32'hC0);
        #1;
        checkOutput("t3_awready", 128'(awready_o), 128'd1);
        checkOutput("t3_wready", 128'(wready_o), 128'd1);
        checkOutput("t3_noslv", 128'({s_awvalid_o, s_wvalid_o}), 128'd0);
        bq.push_back(2'b11);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("t3_bvalid", 128'(bvalid_o), 128'd1);
        nextCycle();
        #1;
        checkOutput("t3_bdone", 128'(bvalid_o), 128'd0);

        // W ahead of AW stalls, then completes through the bypass.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'hD0);
            #1;
            checkOutput("t4_wearly", 128'({wready_o, s_wvalid_o}), 128'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h4000_0000, 1'b1, 32'hD0);
        #1;
        checkOutput("t4_aw", 128'({awready_o, wready_o}), 128'b11);
        checkOutput("t4_swvalid", 128'(s_wvalid_o), 128'b1000);
        checkOutput("t4_swdata", 128'(s_wdata_o), 128'hD0 << 96);
        bq.push_back(2'b11);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        s_bvalid_i = 4'b1000;
        #1;
        checkOutput("t4_bvalid", 128'(bvalid_o), 128'd1);
        nextCycle();
        s_bvalid_i = 4'b0000;

        // Two unmapped reads back to back, R held off then drained.
        arvalid_i = 1'b1; araddr_i = 32'h0; arprot_i = 3'b000; rready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("t5_arready", 128'(arready_o), 128'd1);
            checkOutput("t5_noslv", 128'(s_arvalid_o), 128'd0);
            rq.push_back({2'b11, 32'h0});
            nextCycle();
        end
        arvalid_i = 1'b0;
        #1;
        checkOutput("t5_rheld", 128'({rvalid_o, rresp_o, rdata_o}), 128'({1'b1, 2'b11, 32'h0}));
        nextCycle();
        rready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("t5_rbeat", 128'(rvalid_o), 128'd1);
            nextCycle();
        end
        #1;
        checkOutput("t5_rdone", 128'(rvalid_o), 128'd0);

        // Mapped read routed to slave 2.
        arvalid_i = 1'b1; araddr_i = 32'h3000_0010; arprot_i = 3'b101;
        #1;
        checkOutput("t5_sarvalid", 128'(s_arvalid_o), 128'b0100);
        checkOutput("t5_sarprot", 128'(s_arprot_o), 128'b101 << 6);
        checkOutput("t5_saraddr", 128'(s_araddr_o), 128'h3000_0010 << 64);
        rq.push_back({2'b10, 32'hDDDD_0002});
        nextCycle();
        arvalid_i = 1'b0;
        s_rvalid_i = 4'hF;
        #1;
        checkOutput("t5_srready", 128'(s_rready_o), 128'b0100);
        nextCycle();
        #1;
        checkOutput("t5_rnone", 128'(rvalid_o), 128'd0);
        s_rvalid_i = 4'h0;
        nextCycle();

        // Reset mid-flight with three writes outstanding.
        bready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h1000_0000 + 32'(k * 4), 1'b1, 32'hE0 + 32'(k));
            #1;
            checkOutput("t6_aw", 128'(awready_o), 128'd1);
            bq.push_back(2'b01);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h2000_0000, 1'b1, 32'hE3);
        arvalid_i = 1'b1; araddr_i = 32'h2000_0000;
        s_bvalid_i = 4'hF;
        #1;
        checkOutput("t6_stall", 128'(awready_o), 128'd0);
        checkOutput("t6_bpre", 128'(bvalid_o), 128'd1);
        areset = 1'b1;
        #1;
        checkOutput("t6_rst_valids", 128'({awready_o, wready_o, s_awvalid_o, s_wvalid_o, arready_o,
                    s_arvalid_o, bvalid_o, rvalid_o, s_bready_o, s_rready_o}), 128'd0);
        bq.delete();
        s_bvalid_i = 4'h0;
        nextCycle();
        areset = 1'b0;
        arvalid_i = 1'b0;
        #1;
        checkOutput("t6_aw_after", 128'(awready_o), 128'd1);
        checkOutput("t6_sawvalid", 128'(s_awvalid_o), 128'b0010);
        bq.push_back(2'b10);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        bready_i = 1'b1;
        s_bvalid_i = 4'b0010;
        #1;
        checkOutput("t6_bvalid", 128'(bvalid_o), 128'd1);
        nextCycle();
        s_bvalid_i = 4'b0000;
        #1;
        checkOutput("t6_bdone", 128'(bvalid_o), 128'd0);
        nextCycle();
        nextCycle();

        checkOutput("bq_empty", 128'(bq.size()), 128'd0);
        checkOutput("rq_empty", 128'(rq.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
